// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : div_seq_pkg
// Brief  : Shared ALU opcodes and RV32M divide-op encodings for div_seq.
// Rev    : 1.0
// ============================================================================
package div_seq_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage : div_seq_pkg
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module : div_seq
// Brief  : Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer driving a shared ALU;
//          restoring division, one quotient bit per cycle.
// Rev    : 1.0
// ============================================================================
module div_seq
    import div_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [1:0]        op,
    input  wire logic [XLEN-1:0]   dividend,
    input  wire logic [XLEN-1:0]   divisor,
    output logic                   busy,
    output logic                   done,
    output logic [XLEN-1:0]        result,
    output logic [XLEN-1:0]        alu_src1,
    output logic [XLEN-1:0]        alu_src2,
    output logic [3:0]             alu_opcode,
    input  wire logic [XLEN-1:0]   alu_result,
    input  wire logic              alu_lt_unsigned
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NEG_A = 3'd1;
    localparam logic [2:0] S_NEG_B = 3'd2;
    localparam logic [2:0] S_ITER  = 3'd3;
    localparam logic [2:0] S_FIX   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]       r_state;
    logic [1:0]       r_op;
    logic [XLEN-1:0]  r_a;        // |dividend|, then shifts into the quotient
    logic [XLEN-1:0]  r_b;        // |divisor|
    logic [XLEN-1:0]  r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sa;
    logic             r_sb;
    logic             r_special;
    logic [XLEN-1:0]  r_result;

    logic [XLEN-1:0]  w_shift;
    logic             w_take;
    logic             w_signed;
    logic [XLEN-1:0]  w_fix_val;
    logic             w_fix_neg;
    logic             w_acc_special;
    logic [XLEN-1:0]  w_special_val;

    assign w_signed  = op_is_signed(r_op);
    assign w_shift   = {r_rem[XLEN-2:0], r_a[XLEN-1]};
    // A set top bit means the 33-bit shifted remainder already exceeds any divisor.
    assign w_take    = r_rem[XLEN-1] | ~alu_lt_unsigned;
    assign w_fix_val = op_is_rem(r_op) ? r_rem : r_a;
    assign w_fix_neg = w_signed & (op_is_rem(r_op) ? r_sa : (r_sa ^ r_sb));

    always_comb begin
        w_acc_special = 1'b0;
        w_special_val = '0;
        if (divisor == '0) begin
            w_acc_special = 1'b1;
            w_special_val = op_is_rem(op) ? dividend : '1;
        end else if (op_is_signed(op) && (dividend == c_int_min) && (divisor == '1)) begin
            w_acc_special = 1'b1;
            w_special_val = op_is_rem(op) ? '0 : c_int_min;
        end
    end

    always_comb begin
        alu_src1   = '0;
        alu_src2   = '0;
        alu_opcode = ALU_ADD;
        case (r_state)
            S_NEG_A: if (w_signed && r_a[XLEN-1]) begin
                alu_src2   = r_a;
                alu_opcode = ALU_SUB;
            end
            S_NEG_B: if (w_signed && r_b[XLEN-1]) begin
                alu_src2   = r_b;
                alu_opcode = ALU_SUB;
            end
            S_ITER: begin
                alu_src1   = w_shift;
                alu_src2   = r_b;
                alu_opcode = ALU_SUB;
            end
            S_FIX: if (w_fix_neg) begin
                alu_src2   = w_fix_val;
                alu_opcode = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_special <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op      <= op;
                    r_a       <= dividend;
                    r_b       <= divisor;
                    r_rem     <= '0;
                    r_sa      <= op_is_signed(op) & dividend[XLEN-1];
                    r_sb      <= op_is_signed(op) & divisor[XLEN-1];
                    r_special <= w_acc_special;
                    if (w_acc_special) begin
                        r_result <= w_special_val;
                    end
                    r_state   <= S_NEG_A;
                end
                S_NEG_A: begin
                    if (r_special) begin
                        r_state <= S_DONE;
                    end else begin
                        if (w_signed && r_a[XLEN-1]) begin
                            r_a <= alu_result;
                        end
                        r_state <= S_NEG_B;
                    end
                end
                S_NEG_B: begin
                    if (w_signed && r_b[XLEN-1]) begin
                        r_b <= alu_result;
                    end
                    r_cnt   <= CNT_W'(XLEN - 1);
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_rem <= w_take ? alu_result : w_shift;
                    r_a   <= {r_a[XLEN-2:0], w_take};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_neg ? alu_result : w_fix_val;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule : div_seq
`default_nettype wire
